// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: M register, data-memory handshake with timeout, W register.
// Latency: E->M one edge, M->W one edge plus one edge per wait cycle; StallM freezes upstream while memory waits.
module mem_wb_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  WriteRegE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        StallM,
  output logic [31:0] ALUOutM,
  output logic [4:0]  WriteRegM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic [31:0] ResultW,
  output logic [4:0]  WriteRegW,
  output logic        RegWriteW,
  output logic        mem_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ABORT} state_t;

  logic [31:0] r_alu_m, r_wdata_m;
  logic [4:0]  r_wreg_m;
  logic        r_regwrite_m, r_memtoreg_m, r_memwrite_m;

  logic [31:0] r_alu_w, r_rdata_w;
  logic [4:0]  r_wreg_w;
  logic        r_memtoreg_w, r_regwrite_w;

  state_t      r_state;
  logic [CW-1:0] r_wait_cnt;
  logic        r_err;

  logic w_acc, w_abort, w_stall, w_done;

  assign w_acc   = r_memwrite_m | r_memtoreg_m;
  assign w_abort = w_acc & (r_state == S_ABORT);
  assign w_stall = w_acc & ~mem_ack & ~w_abort;
  assign w_done  = mem_req & mem_ack;

  assign mem_req   = w_acc & ~w_abort;
  assign mem_we    = r_memwrite_m;
  assign mem_addr  = r_alu_m;
  assign mem_wdata = r_wdata_m;

  assign StallM    = w_stall;
  assign ALUOutM   = r_alu_m;
  assign WriteRegM = r_wreg_m;
  assign RegWriteM = r_regwrite_m;
  assign MemtoRegM = r_memtoreg_m;

  assign ResultW   = r_memtoreg_w ? r_rdata_w : r_alu_w;
  assign WriteRegW = r_wreg_w;
  assign RegWriteW = r_regwrite_w;
  assign mem_err   = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_m      <= '0;
      r_wdata_m    <= '0;
      r_wreg_m     <= '0;
      r_regwrite_m <= 1'b0;
      r_memtoreg_m <= 1'b0;
      r_memwrite_m <= 1'b0;
    end else if (!w_stall) begin
      r_alu_m      <= ALUOutE;
      r_wdata_m    <= WriteDataE;
      r_wreg_m     <= WriteRegE;
      r_regwrite_m <= RegWriteE;
      r_memtoreg_m <= MemtoRegE;
      r_memwrite_m <= MemWriteE;
    end
  end

  // The counter only advances while stalled, so reaching MAX_WAIT-1 under stall means the next cycle is the timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else if (!w_stall) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + CW'(1);
      r_state    <= (r_wait_cnt == CW'(MAX_WAIT - 1)) ? S_ABORT : S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_w      <= '0;
      r_rdata_w    <= '0;
      r_wreg_w     <= '0;
      r_memtoreg_w <= 1'b0;
      r_regwrite_w <= 1'b0;
    end else begin
      r_alu_w      <= r_alu_m;
      r_wreg_w     <= r_wreg_m;
      r_memtoreg_w <= r_memtoreg_m;
      // A stalled cycle writes a bubble so the held instruction retires only once.
      r_regwrite_w <= r_regwrite_m & ~w_abort & ~w_stall;
      if (w_abort)
        r_rdata_w <= '0;
      else if (w_done)
        r_rdata_w <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_err <= 1'b0;
    else if (w_abort)
      r_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (MAX_WAIT=4) with a writeback/memory-transaction scoreboard.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ALUOutE = '0, WriteDataE = '0;
  logic [4:0]  WriteRegE = '0;
  logic        RegWriteE = 1'b0, MemtoRegE = 1'b0, MemWriteE = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        StallM;
  logic [31:0] ALUOutM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM, MemtoRegM;
  logic [31:0] ResultW;
  logic [4:0]  WriteRegW;
  logic        RegWriteW;
  logic        mem_err;

  mem_wb_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .StallM(StallM), .ALUOutM(ALUOutM), .WriteRegM(WriteRegM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [36:0] exp_wb[$];   // {reg, result}
  logic [64:0] exp_mem[$];  // {we, addr, wdata}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                       input logic rw, input logic m2r, input logic mw);
    ALUOutE = alu; WriteDataE = wd; WriteRegE = wr;
    RegWriteE = rw; MemtoRegE = m2r; MemWriteE = mw;
  endtask

  task automatic nop();
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every writeback and every completed memory handshake must match the next expectation.
  initial begin
    logic [36:0] e_wb;
    logic [64:0] e_mem;
    forever begin
      @(negedge clk);
      if (rst && RegWriteW) begin
        if (exp_wb.size() == 0) begin
          chk("wb_unexpected", {27'd0, WriteRegW}, 32'hFFFF_FFFF);
        end else begin
          e_wb = exp_wb.pop_front();
          chk("wb_reg", {27'd0, WriteRegW}, {27'd0, e_wb[36:32]});
          chk("wb_result", ResultW, e_wb[31:0]);
        end
      end
      if (rst && mem_req && mem_ack) begin
        if (exp_mem.size() == 0) begin
          chk("mem_unexpected", mem_addr, 32'hFFFF_FFFF);
        end else begin
          e_mem = exp_mem.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, e_mem[64]});
          chk("mem_addr", mem_addr, e_mem[63:32]);
          chk("mem_wdata", mem_wdata, e_mem[31:0]);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_aluoutm", ALUOutM, 32'd0);
    chk("rst_resultw", ResultW, 32'd0);
    chk("rst_regwritew", {31'd0, RegWriteW}, 32'd0);
    chk("rst_regwritem", {31'd0, RegWriteM}, 32'd0);
    step();
    rst = 1'b1;
    step();

    // Zero-wait load
    set_e(32'h10, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
    exp_mem.push_back({1'b0, 32'h10, 32'h0});
    exp_wb.push_back({5'd8, 32'hCAFE0001});
    step();
    #3;
    chk("zw_stall", {31'd0, StallM}, 32'd0);
    chk("zw_req", {31'd0, mem_req}, 32'd1);
    chk("zw_addr", mem_addr, 32'h10);
    nop();
    step();
    #3;
    chk("zw_resultw", ResultW, 32'hCAFE0001);
    chk("zw_wregw", {27'd0, WriteRegW}, 32'd8);
    chk("zw_regwritew", {31'd0, RegWriteW}, 32'd1);
    mem_ack = 1'b0;
    step();

    // ALU instruction
    set_e(32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    exp_wb.push_back({5'd3, 32'h55});
    step();
    #3;
    chk("alu_req", {31'd0, mem_req}, 32'd0);
    chk("alu_aluoutm", ALUOutM, 32'h55);
    chk("alu_wregm", {27'd0, WriteRegM}, 32'd3);
    nop();
    step();
    #3;
    chk("alu_resultw", ResultW, 32'h55);
    chk("alu_regwritew", {31'd0, RegWriteW}, 32'd1);
    step();

    // Store with three wait states; ack lands on the last permitted wait cycle
    set_e(32'h20, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b1);
    exp_mem.push_back({1'b1, 32'h20, 32'h1234});
    step();
    set_e(32'h77, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    exp_wb.push_back({5'd5, 32'h77});
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ack = 1'b1;
      #3;
      chk("st_stall", {31'd0, StallM}, (i < 3) ? 32'd1 : 32'd0);
      chk("st_we", {31'd0, mem_we}, 32'd1);
      chk("st_addr", mem_addr, 32'h20);
      chk("st_wdata", mem_wdata, 32'h1234);
      chk("st_regwritew", {31'd0, RegWriteW}, 32'd0);
      step();
    end
    mem_ack = 1'b0;
    #3;
    chk("st_next_aluoutm", ALUOutM, 32'h77);
    chk("st_regwritew_after", {31'd0, RegWriteW}, 32'd0);
    chk("st_err", {31'd0, mem_err}, 32'd0);
    nop();
    step();
    step();

    // Load stalled for two cycles: bubbles in W, M held
    set_e(32'h40, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    mem_rdata = 32'hBEEF0009;
    exp_mem.push_back({1'b0, 32'h40, 32'h0});
    exp_wb.push_back({5'd9, 32'hBEEF0009});
    step();
    nop();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ack = 1'b1;
      #3;
      chk("bub_stall", {31'd0, StallM}, (i < 2) ? 32'd1 : 32'd0);
      chk("bub_aluoutm", ALUOutM, 32'h40);
      chk("bub_wregm", {27'd0, WriteRegM}, 32'd9);
      chk("bub_regwritew", {31'd0, RegWriteW}, 32'd0);
      step();
    end
    mem_ack = 1'b0;
    #3;
    chk("bub_wb_once", {31'd0, RegWriteW}, 32'd1);
    chk("bub_resultw", ResultW, 32'hBEEF0009);
    step();
    #3;
    chk("bub_no_second_wb", {31'd0, RegWriteW}, 32'd0);
    step();

    // Timeout with MAX_WAIT=4; an ack in the abort cycle must be ignored
    set_e(32'h60, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0);
    mem_rdata = 32'hDEADDEAD;
    step();
    set_e(32'h99, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0);
    exp_wb.push_back({5'd11, 32'h99});
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("to_req", {31'd0, mem_req}, 32'd1);
      chk("to_stall", {31'd0, StallM}, 32'd1);
      step();
    end
    mem_ack = 1'b1;
    #3;
    chk("to_abort_req", {31'd0, mem_req}, 32'd0);
    chk("to_abort_stall", {31'd0, StallM}, 32'd0);
    step();
    mem_ack = 1'b0;
    #3;
    chk("to_err_set", {31'd0, mem_err}, 32'd1);
    chk("to_load_regwritew", {31'd0, RegWriteW}, 32'd0);
    chk("to_load_resultw", ResultW, 32'd0);
    chk("to_next_aluoutm", ALUOutM, 32'h99);
    nop();
    step();
    step();
    #3;
    chk("to_err_sticky", {31'd0, mem_err}, 32'd1);

    // Reset in the middle of a stalled load
    set_e(32'h80, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0);
    step();
    nop();
    step();
    #3;
    chk("rmw_stall_before", {31'd0, StallM}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rmw_req", {31'd0, mem_req}, 32'd0);
    chk("rmw_stall", {31'd0, StallM}, 32'd0);
    chk("rmw_regwritew", {31'd0, RegWriteW}, 32'd0);
    chk("rmw_err", {31'd0, mem_err}, 32'd0);
    step();
    rst = 1'b1;
    step();
    set_e(32'h84, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h13131313;
    exp_mem.push_back({1'b0, 32'h84, 32'h0});
    exp_wb.push_back({5'd13, 32'h13131313});
    step();
    #3;
    chk("rmw_zw_stall", {31'd0, StallM}, 32'd0);
    nop();
    step();
    #3;
    chk("rmw_zw_resultw", ResultW, 32'h13131313);
    mem_ack = 1'b0;
    step();
    step();

    chk("wb_queue_empty", exp_wb.size(), 32'd0);
    chk("mem_queue_empty", exp_mem.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
